// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if
//   Host bus between a CPU-side master and the UART TX controller.
//   Signals:
//     cs_n     master->slave  chip select, active low
//     rw       master->slave  1 = read, 0 = write
//     addr     master->slave  register select (0 data, 1 status, 2 ctrl, 3 reserved)
//     wr_data  master->slave  write data
//     rd_data  slave->master  registered read data
//     rd_oe    slave->master  read output enable for the top-level tristate
interface uart_tx_ctrl_if;
  logic       cs_n;
  logic       rw;
  logic [1:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_oe;

  modport master (output cs_n, rw, addr, wr_data, input rd_data, rd_oe);
  modport slave  (input cs_n, rw, addr, wr_data, output rd_data, rd_oe);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   Bus-facing controller that queues bytes from the host and hands them one
//   at a time to a UART TX core using a latch/busy handshake.
//   Ports:
//     clk       system clock, rising edge
//     rst_n     synchronous active-low reset
//     bus       uart_tx_ctrl_if.slave host bus (cs_n, rw, addr, wr_data, rd_data, rd_oe)
//     tx_data   byte presented to the TX core
//     tx_latch  one-cycle load strobe to the TX core
//     tx_busy   TX core busy flag
//     irq_n     level interrupt, active low (enabled, queue empty, idle)
//   Configuration:
//     UART_TX_CTRL_FIFO_EN  defined: 4-entry FIFO; undefined: single holding register
module uart_tx_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_ctrl_if.slave bus,
  output logic [7:0]    tx_data,
  output logic          tx_latch,
  input  logic          tx_busy,
  output logic          irq_n
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

`ifdef UART_TX_CTRL_FIFO_EN
  localparam logic [2:0] DEPTH = 3'd4;
`else
  localparam logic [2:0] DEPTH = 3'd1;
`endif

  state_t     state, state_nxt;
  logic       wb_wait, wb_wait_nxt;
  logic       launch;
  logic       cs_n_q;
  logic       enable, irq_en, overflow;
  logic [2:0] level;
  logic [7:0] head;
  logic       access, wr_acc, rd_acc;
  logic       push, push_ok, flush;
  logic       empty, full, active;
  logic [7:0] status;

  // An access is the first sampled low of cs_n; holding cs_n low does not repeat it.
  assign access  = !bus.cs_n && cs_n_q;
  assign wr_acc  = access && !bus.rw;
  assign rd_acc  = access && bus.rw;
  assign push    = wr_acc && (bus.addr == 2'd0);
  assign flush   = wr_acc && (bus.addr == 2'd2) && bus.wr_data[7];
  assign empty   = (level == 3'd0);
  assign full    = (level == DEPTH);
  // A pop in the same cycle frees the slot, so a push into a full queue is still taken.
  assign push_ok = push && (!full || launch);
  assign active  = !empty || tx_busy || (state != IDLE);
  assign status  = {1'b0, level, overflow, full, empty, active};

  assign bus.rd_oe = !bus.cs_n && bus.rw;
  assign irq_n     = !(irq_en && empty && (state == IDLE));

  // cs_n history for access edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) cs_n_q <= 1'b1;
    else        cs_n_q <= bus.cs_n;
  end

  // Control register; only enable and irq_en are stored, bit7 is a flush command
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
    end else if (wr_acc && (bus.addr == 2'd2)) begin
      enable <= bus.wr_data[0];
      irq_en <= bus.wr_data[1];
    end
  end

  // Read data is captured on the access and held until the next read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rd_data <= 8'h00;
    end else if (rd_acc) begin
      case (bus.addr)
        2'd1:    bus.rd_data <= status;
        2'd2:    bus.rd_data <= {6'b0, irq_en, enable};
        default: bus.rd_data <= 8'h00;
      endcase
    end
  end

  // Occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n || flush)         level <= 3'd0;
    else if (push_ok && !launch) level <= level + 3'd1;
    else if (!push_ok && launch) level <= level - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush)            overflow <= 1'b0;
    else if (push && full && !launch) overflow <= 1'b1;
  end

`ifdef UART_TX_CTRL_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (launch)  rd_ptr <= rd_ptr + 2'd1;
    end
  end

  assign head = mem[rd_ptr];
`else
  logic [7:0] hold;

  always_ff @(posedge clk) begin
    if (!rst_n)       hold <= 8'h00;
    else if (push_ok) hold <= bus.wr_data;
  end

  assign head = hold;
`endif

  // Handshake state register; the latch strobe is registered so it lasts one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wb_wait  <= 1'b0;
      tx_latch <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      wb_wait  <= wb_wait_nxt;
      tx_latch <= launch;
      if (launch) tx_data <= head;
    end
  end

  // Launch only from IDLE; WAIT_BUSY gives up after two cycles without busy
  always_comb begin
    state_nxt   = state;
    wb_wait_nxt = 1'b0;
    launch      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty && !tx_busy) begin
          launch    = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy)      state_nxt   = WAIT_DONE;
        else if (wb_wait) state_nxt   = IDLE;
        else              wb_wait_nxt = 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
